instruction_memory_loadable: RTL and testbench

//  Parametrised instruction memory for the fetch stage: synchronous read, stall hold, kill-to-NOP

---
 rtl/instruction_memory_loadable.sv | 100 ++++++++++
 tb/tb_instruction_memory_loadable.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loadable.sv
// Fetch-stage instruction memory: one-cycle synchronous read with stall/kill/fault handling,
// plus a run-time program-load port sequenced by an IDLE/LOAD/RUN state machine.
module instruction_memory_loadable #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              kill,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              addr_fault,
    input  logic              load_start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic              load_busy,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              fetch_in_range;
    logic              load_in_range;
    logic              load_accept;

    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_W;
    assign load_in_range  = {1'b0, load_addr} < DEPTH_W;
    assign load_accept    = (state == S_LOAD) && load_we && load_in_range;
    assign load_busy      = (state == S_LOAD);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = S_LOAD;
        end else if (load_done && state != S_RUN) begin
            state_next = S_RUN;
        end
    end

    // NOTE: the array has no reset; a loaded program survives reset and maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_accept) mem[load_addr[MEM_AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
            load_count  <= '0;
        end else begin
            if (load_start) begin
                load_count <= '0;
                addr_fault <= 1'b0;
            end else if (load_accept && load_count != COUNT_MAX) begin
                load_count <= load_count + COUNT_ONE;
            end

            // Leaving RUN on this edge counts as non-RUN so LOAD entry shows a bubble at once.
            if (state != S_RUN || load_start) begin
                instruction <= NOP_WORD;
                instr_valid <= 1'b0;
            end else if (kill) begin
                instruction <= NOP_WORD;
                instr_valid <= 1'b0;
            end else if (stall) begin
                instruction <= instruction;
                instr_valid <= instr_valid;
            end else if (!fetch_in_range) begin
                instruction <= NOP_WORD;
                instr_valid <= 1'b0;
                addr_fault  <= 1'b1;
            end else begin
                instruction <= mem[fetch_addr[MEM_AW-1:0]];
                instr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed self-checking bench for instruction_memory_loadable (default parameters).
module tb_instruction_memory_loadable;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, kill;
    logic [15:0] fetch_addr;
    logic [15:0] instruction;
    logic        instr_valid, addr_fault;
    logic        load_start, load_we, load_done;
    logic [15:0] load_addr, load_data;
    logic        load_busy;
    logic [16:0] load_count;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_memory_loadable dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .kill        (kill),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .addr_fault  (addr_fault),
        .load_start  (load_start),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_done   (load_done),
        .load_busy   (load_busy),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a);
        fetch_addr = a;
        tick();
    endtask

    task automatic check_out(input string tag, input logic [15:0] ins, input logic v, input logic f);
        check({tag, ".instr"}, 32'(instruction), 32'(ins));
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".fault"}, 32'(addr_fault), 32'(f));
    endtask

    initial begin
        reset = 1'b1; stall = 0; kill = 0; fetch_addr = 0;
        load_start = 0; load_we = 0; load_addr = 0; load_data = 0; load_done = 0;
        #2;
        check_out("reset", 16'h0000, 1'b0, 1'b0);
        check("reset.busy", 32'(load_busy), 32'h0);
        check("reset.count", 32'(load_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // IDLE: fetching does nothing
        fetch(16'd0);
        check_out("idle", 16'h0000, 1'b0, 1'b0);

        // Program load; address 300 is out of range and must not alias onto word 44
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load.busy", 32'(load_busy), 32'h1);
        check("load.count0", 32'(load_count), 32'h0);
        write_word(16'd0, 16'h1234);
        write_word(16'd1, 16'hABCD);
        write_word(16'd44, 16'h5555);
        check("load.count3", 32'(load_count), 32'h3);
        write_word(16'd300, 16'hFFFF);
        check("load.oob_count", 32'(load_count), 32'h3);
        check_out("load.out", 16'h0000, 1'b0, 1'b0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("run.busy", 32'(load_busy), 32'h0);
        check("run.first_bubble", 32'(instr_valid), 32'h0);

        fetch(16'd0);  check_out("fetch0", 16'h1234, 1'b1, 1'b0);
        fetch(16'd1);  check_out("fetch1", 16'hABCD, 1'b1, 1'b0);
        fetch(16'd44); check_out("fetch44", 16'h5555, 1'b1, 1'b0);

        // Stall holds the previous word for three cycles
        fetch(16'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(16'd1);
            check_out("stall", 16'h1234, 1'b1, 1'b0);
        end
        stall = 1'b0;
        fetch(16'd1); check_out("unstall", 16'hABCD, 1'b1, 1'b0);

        // Kill overrides stall
        stall = 1'b1; kill = 1'b1;
        fetch(16'd0);
        stall = 1'b0; kill = 1'b0;
        check_out("kill", 16'h0000, 1'b0, 1'b0);
        fetch(16'd0); check_out("postkill", 16'h1234, 1'b1, 1'b0);

        // Out-of-range fetch sets a sticky fault; fetching continues
        fetch(16'd256); check_out("fault", 16'h0000, 1'b0, 1'b1);
        fetch(16'd0);   check_out("fault.sticky", 16'h1234, 1'b1, 1'b1);
        fetch(16'd44);  check_out("fault.sticky2", 16'h5555, 1'b1, 1'b1);

        // load_start wins over load_done; LOAD entry clears fault and count
        load_start = 1'b1; load_done = 1'b1;
        tick();
        load_start = 1'b0; load_done = 1'b0;
        check("reload.busy", 32'(load_busy), 32'h1);
        check("reload.count", 32'(load_count), 32'h0);
        check_out("reload", 16'h0000, 1'b0, 1'b0);
        write_word(16'd5, 16'h7777);
        check("reload.count1", 32'(load_count), 32'h1);
        // load_start inside LOAD restarts the count
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("restart.count", 32'(load_count), 32'h0);
        check("restart.busy", 32'(load_busy), 32'h1);
        // Write on the load_done cycle is accepted
        load_we = 1'b1; load_addr = 16'd6; load_data = 16'h6666; load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("done_write.count", 32'(load_count), 32'h1);
        check("done_write.busy", 32'(load_busy), 32'h0);
        // Writes in RUN are ignored
        load_addr = 16'd0; load_data = 16'hDEAD;
        fetch(16'd6);
        load_we = 1'b0;
        check_out("fetch6", 16'h6666, 1'b1, 1'b0);
        check("run_we.count", 32'(load_count), 32'h1);
        fetch(16'd0); check_out("run_we_ignored", 16'h1234, 1'b1, 1'b0);
        fetch(16'd5); check_out("fetch5", 16'h7777, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, away from any clock edge
        fetch(16'd256);
        fetch(16'd5);
        check_out("prereset", 16'h7777, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_out("async_reset", 16'h0000, 1'b0, 1'b0);
        check("async_reset.busy", 32'(load_busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        // load_we in IDLE is ignored; memory survives reset
        write_word(16'd5, 16'h0000);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        fetch(16'd5); check_out("retained", 16'h7777, 1'b1, 1'b0);

        // Reset during LOAD
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        write_word(16'd7, 16'h0101);
        #2 reset = 1'b1;
        #1;
        check("midload_reset.busy", 32'(load_busy), 32'h0);
        check("midload_reset.count", 32'(load_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
